// File: rtl/sr_latch_driver_if.sv
// Command handshake and latch drive bundle between a command source and sr_latch_driver.
interface sr_latch_driver_if;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;
  logic       s;
  logic       r;
  logic       en;
  logic       busy;
  logic       done;
  logic       err;
  logic       q_exp;

  modport master (
    output req_valid, req_op,
    input  req_ready, s, r, en, busy, done, err, q_exp
  );

  modport slave (
    input  req_valid, req_op,
    output req_ready, s, r, en, busy, done, err, q_exp
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Turns set/clear commands into timed setup / enable-pulse / hold drive sequences for a gated SR latch.
module sr_latch_driver #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_latch_driver_if.slave   bus
);

  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          seq_op;

  assign seq_op = (bus.req_op == 2'b01) || (bus.req_op == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.req_ready <= 1'b0;
      bus.s         <= 1'b0;
      bus.r         <= 1'b0;
      bus.en        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.q_exp     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            if (seq_op) begin
              state         <= SETUP;
              cnt           <= CW'(SETUP_CYC - 1);
              bus.s         <= (bus.req_op == 2'b01);
              bus.r         <= (bus.req_op == 2'b10);
              bus.busy      <= 1'b1;
              bus.req_ready <= 1'b0;
            end else if (bus.req_op == 2'b11) begin
              bus.err <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state  <= ENABLE;
            cnt    <= CW'(PULSE_CYC - 1);
            bus.en <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ENABLE: begin
          if (cnt == '0) begin
            state     <= HOLD;
            cnt       <= CW'(HOLD_CYC - 1);
            bus.q_exp <= bus.s;
            bus.en    <= 1'b0;
            bus.s     <= 1'b0;
            bus.r     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            bus.done <= 1'b1;
            // A waiting set/clear is taken on the done edge itself so back-to-back
            // sequences have no idle gap; no-op/illegal ops wait for IDLE.
            if (bus.req_valid && seq_op) begin
              state    <= SETUP;
              cnt      <= CW'(SETUP_CYC - 1);
              bus.s    <= (bus.req_op == 2'b01);
              bus.r    <= (bus.req_op == 2'b10);
              bus.busy <= 1'b1;
            end else begin
              state         <= IDLE;
              bus.busy      <= 1'b0;
              bus.req_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: default timing on one instance, SETUP=3/PULSE=1/HOLD=2 on another.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_latch_driver_if a ();
  sr_latch_driver_if b ();

  sr_latch_driver dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  sr_latch_driver #(
    .SETUP_CYC (3),
    .PULSE_CYC (1),
    .HOLD_CYC  (2)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector order: {req_ready, s, r, en, busy, done, err, q_exp}
  function automatic logic [7:0] va();
    return {a.req_ready, a.s, a.r, a.en, a.busy, a.done, a.err, a.q_exp};
  endfunction

  function automatic logic [7:0] vb();
    return {b.req_ready, b.s, b.r, b.en, b.busy, b.done, b.err, b.q_exp};
  endfunction

  localparam logic [7:0] A_SET0 [9] = '{8'b01001000, 8'b01011000, 8'b01011000, 8'b00001001,
                                        8'b10000101, 8'b10000001, 8'h00, 8'h00, 8'h00};
  localparam logic [7:0] A_SETCLR [9] = '{8'b01001000, 8'b01011000, 8'b01011000, 8'b00001001,
                                          8'b00101101, 8'b00111001, 8'b00111001, 8'b00001000,
                                          8'b10000100};
  localparam logic [7:0] B_SET [9] = '{8'b01001000, 8'b01001000, 8'b01001000, 8'b01011000,
                                       8'b00001001, 8'b00001001, 8'b10000101, 8'h00, 8'h00};
  localparam logic [7:0] B_CLR [9] = '{8'b00101001, 8'b00101001, 8'b00101001, 8'b00111001,
                                       8'b00001000, 8'b00001000, 8'b10000100, 8'h00, 8'h00};

  task automatic run_a(input logic [1:0] op, input logic [7:0] tbl [9], input int unsigned n, input string tag);
    a.req_valid = 1'b1;
    a.req_op    = op;
    tick();
    a.req_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (i > 0) tick();
      check_eq($sformatf("%s[%0d]", tag, i), 32'(va()), 32'(tbl[i]));
    end
  endtask

  task automatic run_b(input logic [1:0] op, input logic [7:0] tbl [9], input int unsigned n, input string tag);
    b.req_valid = 1'b1;
    b.req_op    = op;
    tick();
    b.req_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (i > 0) tick();
      check_eq($sformatf("%s[%0d]", tag, i), 32'(vb()), 32'(tbl[i]));
    end
  endtask

  // srlatch reference models and always-on drive safety checks
  logic qa_m = 1'b0, qb_m = 1'b0;
  logic pa_s = 1'b0, pa_r = 1'b0, pa_en = 1'b0;
  logic pb_s = 1'b0, pb_r = 1'b0, pb_en = 1'b0;

  always @(negedge clk) begin
    check_eq("a_sr_excl", 32'(a.s & a.r), 32'd0);
    check_eq("b_sr_excl", 32'(b.s & b.r), 32'd0);
    if (a.s != pa_s || a.r != pa_r) check_eq("a_en_across_sr", 32'(pa_en & a.en), 32'd0);
    if (b.s != pb_s || b.r != pb_r) check_eq("b_en_across_sr", 32'(pb_en & b.en), 32'd0);
    if (a.done) check_eq("a_model_q", 32'(a.q_exp), 32'(qa_m));
    if (b.done) check_eq("b_model_q", 32'(b.q_exp), 32'(qb_m));
    if (a.en) qa_m = a.s ? 1'b1 : (a.r ? 1'b0 : qa_m);
    if (b.en) qb_m = b.s ? 1'b1 : (b.r ? 1'b0 : qb_m);
    pa_s = a.s; pa_r = a.r; pa_en = a.en;
    pb_s = b.s; pb_r = b.r; pb_en = b.en;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int unsigned dones;
    int unsigned ens;
    logic        got_done;

    a.req_valid = 1'b0; a.req_op = 2'b00;
    b.req_valid = 1'b0; b.req_op = 2'b00;
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("reset_a", 32'(va()), 32'd0);
    check_eq("reset_b", 32'(vb()), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_reset_a", 32'(va()), 32'(8'b10000000));
    check_eq("ready_after_reset_b", 32'(vb()), 32'(8'b10000000));

    // Set with default timing
    run_a(2'b01, A_SET0, 6, "t1_set");

    // No-op then two illegal ops on consecutive cycles
    a.req_valid = 1'b1;
    a.req_op = 2'b00; tick(); check_eq("t3_noop",  32'(va()), 32'(8'b10000001));
    a.req_op = 2'b11; tick(); check_eq("t3_ill0",  32'(va()), 32'(8'b10000011));
    a.req_op = 2'b11; tick(); check_eq("t3_ill1",  32'(va()), 32'(8'b10000011));
    a.req_valid = 1'b0;
    tick();                   check_eq("t3_after", 32'(va()), 32'(8'b10000001));

    rst_n = 1'b0;
    tick();
    check_eq("t2_pre_reset", 32'(va()), 32'd0);
    rst_n = 1'b1;
    tick();

    // Set then clear held valid: clear taken on the set's done edge
    a.req_valid = 1'b1;
    a.req_op    = 2'b01;
    tick();
    check_eq("t2_seq[0]", 32'(va()), 32'(A_SETCLR[0]));
    a.req_op = 2'b10;
    for (int unsigned i = 1; i < 9; i++) begin
      tick();
      if (i == 4) a.req_valid = 1'b0;
      check_eq($sformatf("t2_seq[%0d]", i), 32'(va()), 32'(A_SETCLR[i]));
    end

    // Clear stalled behind a running set
    a.req_valid = 1'b1;
    a.req_op    = 2'b01;
    tick();
    a.req_op = 2'b10;
    got_done = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      if (a.done) begin
        got_done = 1'b1;
        break;
      end
      check_eq("t4_ready_low", 32'(a.req_ready), 32'd0);
    end
    check_eq("t4_done_seen", 32'(got_done), 32'd1);
    check_eq("t4_taken", 32'({a.busy, a.r, a.req_ready}), 32'(3'b110));
    a.req_valid = 1'b0;
    dones = 0;
    ens   = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      dones += 32'(a.done);
      ens   += 32'(a.en);
    end
    check_eq("t4_one_done", dones, 32'd1);
    check_eq("t4_en_cycles", ens, 32'd2);
    check_eq("t4_final", 32'(va()), 32'(8'b10000000));

    // Reset while en is high
    a.req_valid = 1'b1;
    a.req_op    = 2'b01;
    tick();
    a.req_valid = 1'b0;
    tick();
    check_eq("t5_en_high", 32'(a.en), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("t5_async_clear", 32'(va()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("t5_ready_first_edge", 32'(va()), 32'(8'b10000000));
    run_a(2'b01, A_SET0, 6, "t5_set");

    // SETUP=3, PULSE=1, HOLD=2 instance
    run_b(2'b01, B_SET, 7, "t6_set");
    run_b(2'b10, B_CLR, 7, "t6_clr");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Upstream command stage for the gated SR latch (`srlatch`). Accepts set/clear commands over a valid/ready handshake and turns each into a glitch-free, timed `s`/`r`/`en` drive sequence: data set up with `en` low, an enable pulse, then a quiet hold. It never drives `s` and `r` high together, and it tracks the latch's expected output so downstream logic can check `q`.

## Interface
- `SETUP_CYC`, default 1: cycles `s`/`r` are held stable with `en`=0 before the enable pulse (legal values ≥1).
- `PULSE_CYC`, default 2: width of the `en` pulse in cycles (legal values ≥1).
- `HOLD_CYC`, default 1: cycles with `s`=`r`=`en`=0 after the pulse (legal values ≥1).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  command present.
- `req_op`  in  2  command code: 00 no-op, 01 set, 10 clear, 11 illegal.
- `req_ready`  out  1  block can accept a command this cycle.
- `s`  out  1  latch set drive.
- `r`  out  1  latch reset drive.
- `en`  out  1  latch enable drive.
- `busy`  out  1  a set/clear sequence is in progress.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `err`  out  1  one-cycle pulse when an illegal op is consumed.
- `q_exp`  out  1  expected latch output after the last completed sequence.

## Operation
- All outputs are registered. Reset values: `s`=`r`=`en`=0, `busy`=0, `done`=0, `err`=0, `q_exp`=0, `req_ready`=0. The FSM resets to IDLE.
- Handshake: a command is accepted on a rising edge where `req_valid`=1 and `req_ready`=1. `req_op` is sampled only then. `req_valid` may drop without being accepted.
- **FSM states:** IDLE, SETUP, ENABLE, HOLD. A down-counter sized for the largest of `SETUP_CYC`, `PULSE_CYC` and `HOLD_CYC` times each state.
- **IDLE** (`req_ready`=1, `busy`=0):
  - op 00: consumed, stay in IDLE, no output change.
  - op 11: consumed, stay in IDLE, `err`=1 for the next cycle.
  - op 01: go to SETUP with `s`=1, `r`=0.
  - op 10: go to SETUP with `s`=0, `r`=1.
  - `req_ready` goes to 0 on the same edge that accepts op 01 or op 10.
- **SETUP:** `en`=0 and `s`/`r` held, for `SETUP_CYC` cycles, then go to ENABLE.
- **ENABLE:** `en`=1 and `s`/`r` held, for `PULSE_CYC` cycles.
  - On the edge leaving ENABLE: `q_exp` updates (1 for set, 0 for clear), and `en`, `s` and `r` all go to 0 together.
  - Then go to HOLD.
- **HOLD:** all drives 0, for `HOLD_CYC` cycles, then go to IDLE with `done`=1 for one cycle and `req_ready`=1.
- `s` and `r` are never both 1 in any state. `s`/`r` never change while `en`=1.
- A set when `q_exp` is already 1 (or a clear when it is already 0) still runs the full sequence.
- Commands presented while `req_ready`=0 are stalled, not dropped.
- Reset asserted mid-sequence: all outputs return to their reset values immediately (asynchronously), the FSM goes to IDLE, and the in-flight command is lost. `q_exp` returns to 0.

## Timing
- `req_ready` first rises on the first rising edge after `rst_n` deasserts.
- With acceptance at edge T0:
  - `s`/`r` valid from T0.
  - `en` high from T0+`SETUP_CYC` to T0+`SETUP_CYC`+`PULSE_CYC`.
  - `q_exp` valid at T0+`SETUP_CYC`+`PULSE_CYC`.
  - `done` and `req_ready` high at T0+`SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC`.
- Busy span: `busy`=1 for exactly `SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC` cycles. With defaults that is 4 cycles.
- Back-to-back throughput: a command held valid is accepted on the same edge `done` rises. The next sequence therefore starts with no idle gap, and `done` and `busy` are both 1 for that cycle.
- Op 00 and op 11 each take one cycle. `req_ready` stays 1 throughout, so consecutive no-op/illegal commands are accepted every cycle.

## Test plan
1. **Set, defaults.** Release reset, then present op 01 for one handshake.
   - `s`=1 from T0; `en`=1 during cycles T0+1 to T0+2; `q_exp`=1 at T0+3; `done`=1 and `req_ready`=1 at T0+4.
   - `r`=0 throughout.
2. **Clear after set.** Run op 01 then op 10, both held valid.
   - The second command is accepted at the first `done` edge.
   - `q_exp` goes 0→1→0.
   - `s` and `r` are never both 1, and `en` is never high across an `s`/`r` change.
3. **Op 00 and op 11.** Present 00, 11, 11 on consecutive cycles.
   - No `en` activity; `busy`=0 throughout.
   - `err` is high for two cycles; `req_ready` stays 1.
4. **Stall.** Hold op 10 valid while a set sequence is busy.
   - `req_ready`=0 until `done`; the clear is then accepted exactly once.
5. **Reset mid-pulse.** Assert `rst_n`=0 while `en`=1.
   - `s`=`r`=`en`=`q_exp`=0 immediately.
   - After release, `req_ready`=1 at the first edge and a new set completes normally.
6. **Parameter sweep** with `SETUP_CYC`=3, `PULSE_CYC`=1, `HOLD_CYC`=2.
   - `en` is one cycle wide, starting 3 cycles after acceptance.
   - `done` arrives 6 cycles after acceptance.
   - The bench's `srlatch` model `q` matches `q_exp` after every `done`.
